// File: rtl/freq_pkg.sv
// Shared definitions for the auto-ranging frequency meter.
// Holds the FSM state encoding, gate-range constants, the gate-length helper
// and the 7-segment code table (active-high, segment a in bit 0).
package freq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Range codes: the result is the frequency in units of 10^range Hz
  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;
  localparam logic [1:0] RANGE_1MS   = 2'd3;

  // Gate length in sysclk cycles; never below one cycle for tiny clocks
  function automatic int unsigned gate_len(input int unsigned clk_hz,
                                           input logic [1:0]  rng);
    int unsigned div;
    case (rng)
      RANGE_1S:    div = 32'd1;
      RANGE_100MS: div = 32'd10;
      RANGE_10MS:  div = 32'd100;
      default:     div = 32'd1000;
    endcase
    gate_len = clk_hz / div;
    if (gate_len == 32'd0) gate_len = 32'd1;
  endfunction

  // Index = BCD nibble; codes 10..15 are blank
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,  // 15..10
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,         // 9..5
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F          // 4..0
  };

endpackage

// File: rtl/bcd_cnt.sv
// Saturating multi-decade BCD counter.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   clr         : synchronous clear of count and overflow flag (wins over inc)
//   inc         : add one; at all nines the count holds and ovf is set
//   count       : DIGITS BCD nibbles, digit 0 in the LSBs
//   ovf         : sticky overflow flag until the next clear
module bcd_cnt
  import freq_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] count,
  output logic                ovf
);

  localparam int unsigned BW = 4 * DIGITS;

  logic [BW-1:0] count_inc;
  logic          carry;
  logic          all_nines;

  // Full ripple increment across all decades within one cycle
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Saturation point: every decade at nine
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (count[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (all_nines) ovf   <= 1'b1;
      else           count <= count_inc;
    end
  end

endmodule

// File: rtl/freq_meter_auto.sv
// Auto-ranging frequency meter with BCD and 7-segment result.
// Ports:
//   sysclk     : system clock, all state on its rising edge
//   rst        : async active-low reset
//   sig_in     : NCH signals under measurement (async to sysclk)
//   ch_sel     : selected channel; a change during a gate aborts that window
//   range_sel  : manual range (0=1 s .. 3=1 ms gate)
//   auto_en    : 1 = auto-ranging, 0 = range taken from range_sel
//   bcd_out    : latched result, digit 0 in the LSBs
//   seg_out    : combinational 7-segment decode of bcd_out
//   range_out  : range that produced bcd_out
//   over       : latched result saturated
//   valid      : one-cycle pulse when a new result is latched
module freq_meter_auto
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned NCH    = 4,
  parameter int unsigned DIGITS = 4
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic [NCH-1:0]         sig_in,
  input  logic [$clog2(NCH)-1:0] ch_sel,
  input  logic [1:0]             range_sel,
  input  logic                   auto_en,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic [7*DIGITS-1:0]    seg_out,
  output logic [1:0]             range_out,
  output logic                   over,
  output logic                   valid
);

  localparam int unsigned CSW = $clog2(NCH);
  localparam int unsigned BW  = 4 * DIGITS;

  state_t         state;
  state_t         next_state;
  logic [NCH-1:0] sync0;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] rise_vec;
  logic           rise_sel;
  logic [CSW-1:0] ch_sel_q;
  logic           abort;
  logic [31:0]    timer;
  logic [31:0]    gate_cur;
  logic           timer_last;
  logic [1:0]     cur_range;
  logic [1:0]     auto_adj;
  logic [1:0]     range_next;
  logic [BW-1:0]  cnt;
  logic           cnt_ovf;
  logic           cnt_clr;
  logic           cnt_inc;
  logic           timer_clr;
  logic           range_load;
  logic           latch_en;

  // Two-flop synchronizer on every channel plus a third flop for edge
  // detection, so switching channels never fabricates an edge
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync0 <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync0 <= sig_in;
      sync1 <= sync0;
      sync2 <= sync1;
    end
  end

  assign rise_vec = sync1 & ~sync2;

  // Channel mux written as a compare loop to stay in range for any NCH
  always_comb begin
    rise_sel = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (ch_sel == CSW'(i)) rise_sel = rise_vec[i];
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) ch_sel_q <= '0;
    else      ch_sel_q <= ch_sel;
  end

  assign abort      = (state == ST_GATE) && (ch_sel != ch_sel_q);
  assign gate_cur   = gate_len(CLK_HZ, cur_range);
  assign timer_last = (timer == gate_cur - 32'd1);

  // Auto-range step, evaluated on the count being latched
  always_comb begin
    auto_adj = cur_range;
    if (cnt_ovf && (cur_range != RANGE_1MS)) begin
      auto_adj = cur_range + 2'd1;
    end else if ((cnt[BW-1 -: 4] == 4'd0) && (cur_range != RANGE_1S)) begin
      auto_adj = cur_range - 2'd1;
    end
  end

  // Range for the window about to start; only the LATCH exit adjusts it
  always_comb begin
    range_next = range_sel;
    if (auto_en) range_next = (state == ST_LATCH) ? auto_adj : cur_range;
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state and control decode
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    timer_clr  = 1'b0;
    range_load = 1'b0;
    latch_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = ST_GATE;
        cnt_clr    = 1'b1;
        timer_clr  = 1'b1;
        range_load = 1'b1;
      end
      ST_GATE: begin
        if (abort) begin
          cnt_clr   = 1'b1;
          timer_clr = 1'b1;
        end else begin
          cnt_inc = rise_sel;
          if (timer_last) next_state = ST_LATCH;
        end
      end
      ST_LATCH: begin
        next_state = ST_GATE;
        latch_en   = 1'b1;
        cnt_clr    = 1'b1;
        timer_clr  = 1'b1;
        range_load = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst)           timer <= '0;
    else if (timer_clr) timer <= '0;
    else                timer <= timer + 32'd1;
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst)            cur_range <= RANGE_1S;
    else if (range_load) cur_range <= range_next;
  end

  bcd_cnt #(
    .DIGITS (DIGITS)
  ) u_cnt (
    .clk   (sysclk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .ovf   (cnt_ovf)
  );

  // Result registers; valid follows the LATCH cycle by one clock
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      bcd_out   <= '0;
      range_out <= RANGE_1S;
      over      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= latch_en;
      if (latch_en) begin
        bcd_out   <= cnt;
        range_out <= cur_range;
        over      <= cnt_ovf;
      end
    end
  end

  // Display decode straight from the latched result
  always_comb begin
    seg_out = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      seg_out[7*i +: 7] = SEG_TABLE[bcd_out[4*i +: 4]];
    end
  end

endmodule

// File: tb/tb_freq_meter_auto.sv
// Directed bench for freq_meter_auto at CLK_HZ=1000: a 4-digit/4-channel
// instance and a 2-digit/2-channel instance share one clock.
module tb_freq_meter_auto;

  localparam logic [6:0] S0 = 7'h3F;
  localparam logic [6:0] S1 = 7'h06;
  localparam logic [6:0] S9 = 7'h6F;

  logic        clk;
  logic        rst4, rst2;
  logic [3:0]  sig4;
  logic [1:0]  sig2;
  logic [1:0]  ch4;
  logic [0:0]  ch2;
  logic [1:0]  rs4, rs2;
  logic        au4, au2;
  logic [15:0] bcd4;
  logic [27:0] seg4;
  logic [1:0]  rng4;
  logic        ovr4, valid4;
  logic [7:0]  bcd2;
  logic [13:0] seg2;
  logic [1:0]  rng2;
  logic        ovr2, valid2;

  logic [2:0]  g4;
  logic        g2;
  logic        p3;
  int          cyc;
  int          per2;
  int          tests;
  int          fails;
  int          n;

  assign sig4 = {p3, g4};
  assign sig2 = {1'b0, g2};

  freq_meter_auto #(.CLK_HZ(1000), .NCH(4), .DIGITS(4)) u_dut4 (
    .sysclk    (clk),
    .rst       (rst4),
    .sig_in    (sig4),
    .ch_sel    (ch4),
    .range_sel (rs4),
    .auto_en   (au4),
    .bcd_out   (bcd4),
    .seg_out   (seg4),
    .range_out (rng4),
    .over      (ovr4),
    .valid     (valid4)
  );

  freq_meter_auto #(.CLK_HZ(1000), .NCH(2), .DIGITS(2)) u_dut2 (
    .sysclk    (clk),
    .rst       (rst2),
    .sig_in    (sig2),
    .ch_sel    (ch2),
    .range_sel (rs2),
    .auto_en   (au2),
    .bcd_out   (bcd2),
    .seg_out   (seg2),
    .range_out (rng2),
    .over      (ovr2),
    .valid     (valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square waves: ch0 period 25, ch1 period 10, ch2 period 20; dut2 period per2
  initial begin
    cyc  = 0;
    per2 = 10;
    g4   = 3'b000;
    g2   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      g4[0] = ((cyc % 25) < 12);
      g4[1] = ((cyc % 10) < 5);
      g4[2] = ((cyc % 20) < 10);
      g2    = ((cyc % per2) < (per2 / 2));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the selected instance's valid, sampled on falling edges
  task automatic wait_valid(input bit use4, input int max_cyc, output int cnt);
    logic v;
    cnt = 0;
    v   = 1'b0;
    while (!v && cnt < max_cyc) begin
      @(negedge clk);
      cnt++;
      v = use4 ? valid4 : valid2;
    end
    tests++;
    assert (v === 1'b1) else begin
      fails++;
      $error("FAIL valid_timeout observed=no_pulse_after_%0d expected=pulse", cnt);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst4 = 1'b0; rst2 = 1'b0;
    ch4  = 2'd1; ch2  = 1'b0;
    rs4  = 2'd0; rs2  = 2'd0;
    au4  = 1'b0; au2  = 1'b1;
    p3   = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_bcd4",   32'(bcd4),   32'h0);
    chk("rst_seg4",   32'(seg4),   32'({S0, S0, S0, S0}));
    chk("rst_rng4",   32'(rng4),   32'd0);
    chk("rst_over4",  32'(ovr4),   32'd0);
    chk("rst_valid4", 32'(valid4), 32'd0);
    chk("rst_seg2",   32'(seg2),   32'({S0, S0}));

    // Manual 1 s gate, channel 1 at period 10
    rst4 = 1'b1;
    wait_valid(1'b1, 1100, n);
    chk("first_latency", 32'(n >= 1002), 32'd1);
    chk("first_over",    32'(ovr4),      32'd0);
    wait_valid(1'b1, 1100, n);
    chk("period_1001",   32'(n),    32'd1001);
    chk("bcd_0100",      32'(bcd4), 32'h0100);
    chk("seg_0100",      32'(seg4), 32'({S0, S1, S0, S0}));
    chk("rng_0",         32'(rng4), 32'd0);
    @(negedge clk);
    chk("valid_one_cyc", 32'(valid4), 32'd0);

    // Range change mid-gate only affects the next window
    repeat (299) @(negedge clk);
    rs4 = 2'd2;
    wait_valid(1'b1, 1100, n);
    chk("midgate_len",   32'(n),    32'd701);
    chk("midgate_rng",   32'(rng4), 32'd0);
    chk("midgate_bcd",   32'(bcd4), 32'h0100);
    wait_valid(1'b1, 20, n);
    chk("r2_len",        32'(n),    32'd11);
    chk("r2_bcd",        32'(bcd4), 32'h0001);
    chk("r2_rng",        32'(rng4), 32'd2);
    rs4 = 2'd0;
    wait_valid(1'b1, 20, n);
    chk("r2_again_rng",  32'(rng4), 32'd2);
    wait_valid(1'b1, 1100, n);
    chk("back_r0_len",   32'(n),    32'd1001);
    chk("back_r0_bcd",   32'(bcd4), 32'h0100);

    // Channel switches abort the running window
    ch4 = 2'd0;
    wait_valid(1'b1, 1100, n);
    chk("ch0_len",       32'(n),    32'd1002);
    chk("ch0_bcd",       32'(bcd4), 32'h0040);
    repeat (500) @(negedge clk);
    ch4 = 2'd2;
    wait_valid(1'b1, 1100, n);
    chk("abort_len",     32'(n),    32'd1002);
    chk("ch2_bcd",       32'(bcd4), 32'h0050);

    // Edge landing on the last gate cycle (idle channel 3, hand-placed pulses)
    ch4 = 2'd3;
    wait_valid(1'b1, 1100, n);
    chk("ch3_zero",      32'(bcd4), 32'h0000);
    repeat (997) @(negedge clk);
    p3 = 1'b1;
    wait_valid(1'b1, 20, n);
    chk("last_cyc_len",  32'(n),    32'd4);
    chk("last_cyc_bcd",  32'(bcd4), 32'h0001);
    p3 = 1'b0;
    repeat (996) @(negedge clk);
    p3 = 1'b1;
    wait_valid(1'b1, 20, n);
    chk("no_double_len", 32'(n),    32'd5);
    chk("no_double_bcd", 32'(bcd4), 32'h0001);
    p3 = 1'b0;

    // Reset in the middle of a gate
    ch4 = 2'd1;
    wait_valid(1'b1, 1100, n);
    chk("pre_rst_bcd",   32'(bcd4), 32'h0100);
    repeat (700) @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("mid_rst_bcd",   32'(bcd4),   32'h0);
    chk("mid_rst_seg",   32'(seg4),   32'({S0, S0, S0, S0}));
    chk("mid_rst_rng",   32'(rng4),   32'd0);
    chk("mid_rst_over",  32'(ovr4),   32'd0);
    chk("mid_rst_valid", 32'(valid4), 32'd0);
    repeat (3) @(negedge clk);
    rst4 = 1'b1;
    wait_valid(1'b1, 1200, n);
    chk("post_rst_lat",  32'(n >= 1002), 32'd1);
    wait_valid(1'b1, 1100, n);
    chk("post_rst_bcd",  32'(bcd4), 32'h0100);

    // 2-digit auto-ranging: overflow steps the range up
    rst2 = 1'b1;
    wait_valid(1'b0, 1100, n);
    chk("auto_lat",      32'(n >= 1002), 32'd1);
    chk("auto_sat_bcd",  32'(bcd2), 32'h99);
    chk("auto_sat_ovr",  32'(ovr2), 32'd1);
    chk("auto_sat_rng",  32'(rng2), 32'd0);
    chk("auto_sat_seg",  32'(seg2), 32'({S9, S9}));
    wait_valid(1'b0, 200, n);
    chk("auto_r1_len",   32'(n),    32'd101);
    chk("auto_r1_bcd",   32'(bcd2), 32'h10);
    chk("auto_r1_ovr",   32'(ovr2), 32'd0);
    chk("auto_r1_rng",   32'(rng2), 32'd1);
    wait_valid(1'b0, 200, n);
    chk("auto_stable",   32'(rng2), 32'd1);
    chk("auto_st_bcd",   32'(bcd2), 32'h10);

    // Manual range 1, then auto resumes from it and steps down on a leading zero
    au2  = 1'b0;
    rs2  = 2'd1;
    per2 = 200;
    wait_valid(1'b0, 200, n);
    chk("man_r1_rng",    32'(rng2), 32'd1);
    au2 = 1'b1;
    wait_valid(1'b0, 200, n);
    tests++;
    assert (bcd2 === 8'h00 || bcd2 === 8'h01) else begin
      fails++;
      $error("FAIL low_count_bcd observed=%0h expected=00_or_01", bcd2);
    end
    chk("low_count_rng", 32'(rng2), 32'd1);
    wait_valid(1'b0, 1100, n);
    chk("down_len",      32'(n),    32'd1001);
    chk("down_bcd",      32'(bcd2), 32'h05);
    chk("down_rng",      32'(rng2), 32'd0);
    wait_valid(1'b0, 1100, n);
    chk("floor_bcd",     32'(bcd2), 32'h05);
    chk("floor_rng",     32'(rng2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_meter_auto.md
FREQ_METER_AUTO -- requirements
Module: freq_meter_auto

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning sysclk frequency in Hz.
REQ-002 The block SHALL have parameter NCH, default 4, meaning number of measurable input channels (2..16).
REQ-003 The block SHALL have parameter DIGITS, default 4, meaning BCD digits of result and display (2..8).
REQ-004 Port sysclk  in  1  system clock; all state on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port sig_in  in  NCH  signals under measurement, asynchronous to sysclk.
REQ-007 Port ch_sel  in  clog2(NCH)  selected channel.
REQ-008 Port range_sel  in  2  manual range: 0=1 s gate, 1=100 ms, 2=10 ms, 3=1 ms.
REQ-009 Port auto_en  in  1  1=auto-ranging, 0=manual range from range_sel.
REQ-010 Port bcd_out  out  4*DIGITS  latched result, digit 0 in LSBs.
REQ-011 Port seg_out  out  7*DIGITS  7-segment codes of bcd_out, active-high, segment a in bit 0.
REQ-012 Port range_out  out  2  range that produced bcd_out.
REQ-013 Port over  out  1  latched result saturated.
REQ-014 Port valid  out  1  one-cycle pulse: new result latched.

Function
REQ-015 Selected channel SHALL pass a 2-flop synchronizer then rising-edge detect; each detected edge increments the counter once.
REQ-016 Gate length SHALL be G = CLK_HZ / 10^range cycles; the count is the frequency in units of 10^range Hz.
REQ-017 FSM states SHALL be IDLE, GATE, LATCH; IDLE->GATE one cycle after reset release; GATE->LATCH after exactly G cycles; LATCH->GATE after one cycle.
REQ-018 Counter SHALL clear on entering GATE; an edge detected on the last GATE cycle is counted in that window.
REQ-019 Counter SHALL be DIGITS-decade BCD with ripple carry per cycle and SHALL saturate at all nines, setting an internal overflow flag.
REQ-020 In LATCH: bcd_out, range_out, over update; valid=1 on the following cycle only.
REQ-021 Manual mode: range SHALL be sampled from range_sel on GATE entry; changes mid-gate take effect next window.
REQ-022 Auto mode: after LATCH, overflow and range<3 -> range+1; else most significant digit zero and range>0 -> range-1; else unchanged; limits 0 and 3 hold.
REQ-023 Any ch_sel change during GATE SHALL abort the window: counter cleared, gate timer restarted, no LATCH, no valid.
REQ-024 Switching auto_en 1->0 SHALL apply range_sel at the next GATE entry; 0->1 starts from the current range.
REQ-025 seg_out SHALL be a combinational decode of bcd_out; codes 10..15 display blank.

Reset
REQ-026 On rst low: bcd_out=0, seg_out=code of "0" per digit, range_out=0, over=0, valid=0, range=0, FSM=IDLE, synchronizer flops=0; immediate, mid-gate included.
REQ-027 The first valid after reset release SHALL occur at least G+2 cycles later; no partial window is reported.

Structure
REQ-028 Shared package freq_pkg SHALL hold the state enum, range constants, gate-length function and 7-segment code table.
REQ-029 Sub-module bcd_cnt (DIGITS-parametrised saturating BCD counter with clear, inc, overflow flag) SHALL be instantiated once.

Verification (CLK_HZ=1000 unless noted)
REQ-030 DIGITS=4, manual range 0, sig_in[1] period 10 cycles, ch_sel=1 -> bcd_out=0100, over=0, valid one cycle per 1001-cycle window.
REQ-031 DIGITS=2, auto, range 0, period 10 -> first result 99 over=1 range_out=0; next 10 over=0 range_out=1; range then stable.
REQ-032 DIGITS=2, auto starting at range 1, period 200 -> result 00 or 01 with leading zero -> range_out 0 next, result 05.
REQ-033 ch_sel toggled 0->2 at cycle 500 of a window -> no valid for that window; next valid reports channel 2 only, full G cycles later.
REQ-034 rst low at cycle 700 of a gate -> all outputs at reset values immediately; first valid no earlier than G+2 cycles after release.
REQ-035 Edge on last GATE cycle (period 1000 cycles, phase-aligned) -> counted, result 0001; no double count in next window.
